// File: rtl/id_operand_reader.sv
// id_operand_reader -- decode-stage operand reader for the pipelined RV32 core.
//
// This block drives the register-file read addresses. It merges the RF read
// data with bypass values from the EX, MEM and WB stages, and detects load-use
// hazards, which raise a one-cycle stall. Resolved operands are registered into
// the ID/EX pipeline register. A saturating count of stall cycles is also kept.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   id_valid, id_rs1/2,         instruction in IF/ID and the sources it reads
//     id_use_rs1/2
//   rf_a1/2 (out), rf_rd1/2     RF read addresses (combinational) and read data
//   ex_*/mem_*/wb_*             producers in the EX, MEM and WB stages
//   flush, hold                 squash the ID instruction / freeze the ID/EX register
//   stall (out)                 load-use stall; freezes PC and IF/ID
//   ex_op1/2_q, ex_rs1/2_q,     ID/EX pipeline register
//     ex_valid_q
//   stall_cnt                   saturating count of stall cycles

// Bypass mux for one source operand. The youngest producer wins. A load in EX
// has no data yet, so it is skipped here; the hazard logic stalls for it.
module id_operand_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_rs,
  input  logic [XLEN-1:0] i_rf,
  input  logic            i_ex_we,
  input  logic            i_ex_is_load,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_result,
  input  logic            i_mem_we,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_result,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_op
);
  // Testing rs==0 first means a producer with rd==0 can never match.
  always_comb begin
    o_op = i_rf;
    if (i_rs == 5'd0)                                       o_op = '0;
    else if (i_ex_we && !i_ex_is_load && i_ex_rd == i_rs)   o_op = i_ex_result;
    else if (i_mem_we && i_mem_rd == i_rs)                  o_op = i_mem_result;
    else if (i_wb_we && i_wb_rd == i_rs)                    o_op = i_wb_data;
  end
endmodule

module id_operand_reader #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic [4:0]       rf_a1,
  output logic [4:0]       rf_a2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_we,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic [XLEN-1:0]  ex_op1_q,
  output logic [XLEN-1:0]  ex_op2_q,
  output logic [4:0]       ex_rs1_q,
  output logic [4:0]       ex_rs2_q,
  output logic             ex_valid_q,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NSRC = 2;

  logic [NSRC-1:0][4:0]      w_rs;
  logic [NSRC-1:0][XLEN-1:0] w_rf;
  logic [NSRC-1:0][XLEN-1:0] w_op;
  logic                      w_hz;

  logic [XLEN-1:0]  r_op1, r_op2;
  logic [4:0]       r_rs1, r_rs2;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  assign rf_a1 = id_rs1;
  assign rf_a2 = id_rs2;
  assign w_rs  = {id_rs2, id_rs1};
  assign w_rf  = {rf_rd2, rf_rd1};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    id_operand_fwd #(.XLEN(XLEN)) u_fwd (
      .i_rs         (w_rs[g]),
      .i_rf         (w_rf[g]),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_ex_rd      (ex_rd),
      .i_ex_result  (ex_result),
      .i_mem_we     (mem_we),
      .i_mem_rd     (mem_rd),
      .i_mem_result (mem_result),
      .i_wb_we      (wb_we),
      .i_wb_rd      (wb_rd),
      .i_wb_data    (wb_data),
      .o_op         (w_op[g])
    );
  end

  // A load in EX cannot forward its result, so one bubble is needed. After
  // that bubble the load is in MEM and is picked up via mem_result.
  assign w_hz = ex_we && ex_is_load && (ex_rd != 5'd0) &&
                ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  // A flush squashes the dependent instruction, so it does not need to wait.
  assign stall = id_valid && w_hz && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (flush || (stall && !hold)) begin
      // Squash or bubble. Operands are zeroed whatever id_use_rsN says.
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (!hold) begin
      r_valid <= id_valid;
      r_op1   <= w_op[0];
      r_op2   <= w_op[1];
      r_rs1   <= id_rs1;
      r_rs2   <= id_rs2;
    end
  end

  // Counts cycles in which the stall actually takes effect. The counter holds
  // at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_cnt <= '0;
    else if (stall && !hold && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
  end

  assign ex_op1_q   = r_op1;
  assign ex_op2_q   = r_op2;
  assign ex_rs1_q   = r_rs1;
  assign ex_rs2_q   = r_rs2;
  assign ex_valid_q = r_valid;
  assign stall_cnt  = r_cnt;
endmodule

// File: tb/tb_id_operand_reader.sv
// Directed bench for id_operand_reader (CNT_W=4 so saturation is reachable).
module tb_id_operand_reader;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]       id_rs1, id_rs2, rf_a1, rf_a2;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic             ex_we, ex_is_load, mem_we, wb_we;
  logic [4:0]       ex_rd, mem_rd, wb_rd;
  logic [XLEN-1:0]  ex_result, mem_result, wb_data;
  logic             flush, hold, stall;
  logic [XLEN-1:0]  ex_op1_q, ex_op2_q;
  logic [4:0]       ex_rs1_q, ex_rs2_q;
  logic             ex_valid_q;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_operand_reader #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall(stall), .ex_op1_q(ex_op1_q), .ex_op2_q(ex_op2_q),
    .ex_rs1_q(ex_rs1_q), .ex_rs2_q(ex_rs2_q), .ex_valid_q(ex_valid_q), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic        exwe, exld;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        memwe;
    logic [4:0]  memrd;
    logic [31:0] memres;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbdat;
    logic [31:0] rf1, rf2;
    logic        fl;
    logic        e_stall, e_vld;
    logic [31:0] e_op1, e_op2;
    logic [3:0]  e_cnt;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    rf_rd1 = '0; rf_rd2 = '0;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_result = '0;
    mem_we = 1'b0; mem_rd = '0; mem_result = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_we = v.exwe; ex_is_load = v.exld; ex_rd = v.exrd; ex_result = v.exres;
    mem_we = v.memwe; mem_rd = v.memrd; mem_result = v.memres;
    wb_we = v.wbwe; wb_rd = v.wbrd; wb_data = v.wbdat;
    rf_rd1 = v.rf1; rf_rd2 = v.rf2; flush = v.fl; hold = 1'b0;
  endtask

  // Advance to 1 time unit after the next posedge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  vec_t tbl [10];

  initial begin
    //          vld rs1 rs2 u1 u2 exwe exld exrd exres      memwe memrd memres     wbwe wbrd wbdat      rf1      rf2      fl stl vld op1       op2       cnt
    tbl[0] = '{1, 5,  6,  1, 1, 1,   0,   5,   32'h11,    1,    5,    32'h22,    1,   5,   32'h33,    32'h44,  32'h66,  0, 0,  1,  32'h11,   32'h66,   0};
    tbl[1] = '{1, 5,  6,  1, 1, 0,   0,   5,   32'h11,    1,    5,    32'h22,    1,   5,   32'h33,    32'h44,  32'h66,  0, 0,  1,  32'h22,   32'h66,   0};
    tbl[2] = '{1, 5,  6,  1, 1, 0,   0,   5,   32'h11,    0,    5,    32'h22,    1,   5,   32'h33,    32'h44,  32'h66,  0, 0,  1,  32'h33,   32'h66,   0};
    tbl[3] = '{1, 5,  6,  1, 1, 0,   0,   5,   32'h11,    0,    5,    32'h22,    0,   5,   32'h33,    32'h44,  32'h66,  0, 0,  1,  32'h44,   32'h66,   0};
    // x0: producers writing rd=0 never forward, and rs==0 always reads zero.
    tbl[4] = '{1, 3,  0,  1, 1, 1,   0,   0,   32'hDEAD,  1,    0,    32'hDEAD,  1,   0,   32'hDEAD,  32'h30,  32'h99,  0, 0,  1,  32'h30,   32'h0,    0};
    // Load in EX matching rs1, but rs1 is not used: no stall. The load is not forwarded.
    tbl[5] = '{1, 7,  8,  0, 1, 1,   1,   7,   32'h5555,  0,    0,    32'h0,     0,   0,   32'h0,     32'h70,  32'h80,  0, 0,  1,  32'h70,   32'h80,   0};
    // Invalid instruction: the operands still resolve, and valid is 0.
    tbl[6] = '{0, 9,  10, 1, 1, 0,   0,   0,   32'h0,     0,    0,    32'h0,     1,   10,  32'hAB,    32'h90,  32'hA0,  0, 0,  0,  32'h90,   32'hAB,   0};
    // Load-use on rs2: stall, bubble, counter 1.
    tbl[7] = '{1, 2,  5,  1, 1, 1,   1,   5,   32'h5555,  1,    5,    32'h22,    0,   0,   32'h0,     32'h20,  32'h50,  0, 1,  0,  32'h0,    32'h0,    1};
    // The same hazard with flush: no stall, squashed, counter unchanged.
    tbl[8] = '{1, 2,  5,  1, 1, 1,   1,   5,   32'h5555,  1,    5,    32'h22,    0,   0,   32'h0,     32'h20,  32'h50,  1, 0,  0,  32'h0,    32'h0,    1};
    // The load has moved to MEM and is forwarded.
    tbl[9] = '{1, 2,  5,  1, 1, 0,   0,   0,   32'h0,     1,    5,    32'hCAFE,  0,   0,   32'h0,     32'h20,  32'h50,  0, 0,  1,  32'h20,   32'hCAFE, 1};

    idle();
    rst = 1'b1;
    #12;
    chk("rst_valid", {31'b0, ex_valid_q}, 32'h0);
    chk("rst_op1",   ex_op1_q, 32'h0);
    chk("rst_cnt",   {28'b0, stall_cnt}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      #2;
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("v%0d_rfa1", i),  {27'b0, rf_a1}, {27'b0, tbl[i].rs1});
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, ex_valid_q}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_op1", i),   ex_op1_q, tbl[i].e_op1);
      chk($sformatf("v%0d_op2", i),   ex_op2_q, tbl[i].e_op2);
      chk($sformatf("v%0d_rs1q", i),  {27'b0, ex_rs1_q},
          (tbl[i].fl || tbl[i].e_stall) ? 32'h0 : {27'b0, tbl[i].rs1});
      chk($sformatf("v%0d_rs2q", i),  {27'b0, ex_rs2_q},
          (tbl[i].fl || tbl[i].e_stall) ? 32'h0 : {27'b0, tbl[i].rs2});
      chk($sformatf("v%0d_cnt", i),   {28'b0, stall_cnt}, {28'b0, tbl[i].e_cnt});
    end

    // Load-use on rs1: exactly one stall cycle, then the value is forwarded from MEM.
    idle();
    id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1; rf_rd1 = 32'h77;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
    #2 chk("lu_stall1", {31'b0, stall}, 32'h1);
    tick();
    chk("lu_bubble", {31'b0, ex_valid_q}, 32'h0);
    chk("lu_cnt",    {28'b0, stall_cnt}, 32'h2);
    ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    mem_we = 1'b1; mem_rd = 5'd7; mem_result = 32'hCAFE;
    #2 chk("lu_stall2", {31'b0, stall}, 32'h0);
    tick();
    chk("lu_op1",   ex_op1_q, 32'hCAFE);
    chk("lu_valid", {31'b0, ex_valid_q}, 32'h1);

    // Hold: the register is frozen for 3 cycles, even while a hazard is present.
    idle();
    id_valid = 1'b1; id_rs1 = 5'd4; rf_rd1 = 32'h1234; id_use_rs1 = 1'b1;
    tick();
    chk("hold_load", ex_op1_q, 32'h1234);
    for (int c = 0; c < 3; c++) begin
      hold = 1'b1; id_rs1 = 5'd6; rf_rd1 = 32'h9999 + c;
      ex_we = (c == 1); ex_is_load = (c == 1); ex_rd = 5'd6;
      #2;
      if (c == 1) chk("hold_hz_stall", {31'b0, stall}, 32'h1);
      tick();
      chk($sformatf("hold_op1_%0d", c), ex_op1_q, 32'h1234);
      chk($sformatf("hold_rs1_%0d", c), {27'b0, ex_rs1_q}, 32'h4);
      chk($sformatf("hold_cnt_%0d", c), {28'b0, stall_cnt}, 32'h2);
    end

    // Saturation: 20 consecutive stalls with a 4-bit counter give 15.
    idle();
    id_valid = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
    for (int c = 0; c < 20; c++) tick();
    chk("sat_cnt", {28'b0, stall_cnt}, 32'hF);

    // Reset in the middle of a stall: the clear is immediate, and stall stays combinational.
    idle();
    id_valid = 1'b1; id_rs1 = 5'd3; rf_rd1 = 32'hBEEF;
    tick();
    chk("pre_rst_op1", ex_op1_q, 32'hBEEF);
    id_use_rs1 = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    #1 rst = 1'b1;
    #1;
    chk("mrst_op1",   ex_op1_q, 32'h0);
    chk("mrst_rs1",   {27'b0, ex_rs1_q}, 32'h0);
    chk("mrst_valid", {31'b0, ex_valid_q}, 32'h0);
    chk("mrst_cnt",   {28'b0, stall_cnt}, 32'h0);
    chk("mrst_stall", {31'b0, stall}, 32'h1);
    idle();
    #1 rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/id_operand_reader.md
# id_operand_reader

Decode-stage operand reader for the pipelined RV32 core: the read-side counterpart of the register file. It drives the RF read addresses, merges the RF read data with bypass values from EX, MEM and WB, and detects load-use hazards, raising a one-cycle stall. Resolved operands are registered into the ID/EX pipeline register. A saturating stall counter is also kept for performance monitoring.

## Interface
- `XLEN`, 32: data width.
- `CNT_W`, 16: stall counter width.
- `clk` in 1: clock. The ID/EX register updates on the posedge; the RF writes on the negedge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: the IF/ID register holds a valid instruction.
- `id_rs1`, `id_rs2` in 5: source register indices.
- `id_use_rs1`, `id_use_rs2` in 1: the instruction actually reads that source.
- `rf_a1`, `rf_a2` out 5: RF read addresses. Combinational: `id_rs1` and `id_rs2`.
- `rf_rd1`, `rf_rd2` in XLEN: RF read data.
- `ex_we`, `ex_is_load` in 1; `ex_rd` in 5; `ex_result` in XLEN: EX-stage producer.
- `mem_we` in 1; `mem_rd` in 5; `mem_result` in XLEN: MEM-stage producer. For loads this is the load data.
- `wb_we` in 1; `wb_rd` in 5; `wb_data` in XLEN: WB-stage producer.
- `flush` in 1: squash the instruction in ID (taken branch or jump).
- `hold` in 1: a downstream stall; freeze the ID/EX register.
- `stall` out 1: combinational. Freeze PC and IF/ID.
- `ex_op1_q`, `ex_op2_q` out XLEN: registered operands.
- `ex_rs1_q`, `ex_rs2_q` out 5: registered source indices.
- `ex_valid_q` out 1: registered valid.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- **Operand resolution (per source s, combinational).** The first match below wins:
  1. s == 0 → 0.
  2. `ex_we` && `ex_rd`==s && !`ex_is_load` → `ex_result`.
  3. `mem_we` && `mem_rd`==s → `mem_result`.
  4. `wb_we` && `wb_rd`==s → `wb_data`.
  5. Otherwise → `rf_rdN`.
- Producers with rd==0 never match.
- **Load-use hazard.** `hz` = `ex_we` && `ex_is_load` && `ex_rd`!=0 && ((`id_use_rs1` && `ex_rd`==`id_rs1`) || (`id_use_rs2` && `ex_rd`==`id_rs2`)).
- **Stall.** `stall` = `id_valid` && `hz` && !`flush`.
- **ID/EX register update at posedge.** The first condition that holds applies:
  - `flush`: `ex_valid_q`←0. Operand and index registers ←0.
  - `hold`: all registers keep their values.
  - `stall`: insert a bubble. `ex_valid_q`←0, operands ←0, indices ←0.
  - Otherwise: `ex_valid_q`←`id_valid`, `ex_op1_q` and `ex_op2_q` ← resolved operands, `ex_rs1_q` and `ex_rs2_q` ← `id_rs1` and `id_rs2`.
- **Stall counter.** It increments on each posedge where `stall` && !`hold`, and saturates at 2^CNT_W−1.
- Operand values are zeroed for bubbles and squashed instructions regardless of `id_use_rsN`.

## Timing
- **Reset.** All `ex_*_q` outputs are 0, `ex_valid_q` is 0 and `stall_cnt` is 0. Reset takes effect immediately on `rst` rising, including mid-stall. `stall` and `rf_aN` remain combinational during reset.
- **Latency.** The ID inputs appear on the `ex_*_q` outputs one posedge later.
- **Hazard resolution.** The load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and is forwarded via `mem_result`.
- **RF write ordering.** The RF writes on the negedge, so `rf_rdN` already reflects the WB write before the posedge. WB bypass gives the same value, so there is no conflict.
- **Simultaneous events.**
  - `flush` with `hz`: `stall`=0, a bubble is inserted, and the counter does not increment.
  - `hold` with `hz`: `stall`=1 and the registers are frozen.
- **Counter wrap.** Wrap is forbidden: the counter holds at all-ones.

## Test plan
- **Forward priority.** rs1=5, EX writes x5=0x11, MEM writes x5=0x22, WB writes x5=0x33, RF holds 0x44 → after the posedge `ex_op1_q`=0x11. With EX dropped → 0x22. With MEM also dropped → 0x33. With no producers → 0x44.
- **x0.** rs2=0 with EX, MEM and WB all writing rd=0 with 0xDEAD → `ex_op2_q`=0.
- **Load-use.** A load to x7 is in EX and the ID instruction uses rs1=7.
  - Expect `stall`=1 for exactly one cycle, a bubble (`ex_valid_q`=0), and `stall_cnt`=1.
  - Next cycle, with `mem_result`=0xCAFE, expect `ex_op1_q`=0xCAFE and `ex_valid_q`=1.
  - Repeat with `id_use_rs1`=0 → no stall.
- **Flush vs. hazard.** Load-use condition plus `flush`=1 → `stall`=0, `ex_valid_q`=0, counter unchanged.
- **Hold.** Load the ID/EX register with op1=0x1234, then assert `hold` with new ID inputs for 3 cycles → `ex_op1_q` stays 0x1234.
- **Reset and saturation.**
  - Reset mid-stall → all outputs 0 immediately.
  - With CNT_W=4, 20 consecutive stalls → `stall_cnt`=15.
